// File: rtl/mem_sram_responder.sv
// rtl/mem_sram_responder.sv - byte/halfword/word request responder for an async 16-bit SRAM
// One-entry pending slot; 32-bit accesses split into two halfword beats (low first).
module mem_sram_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int INIT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [25:0] mem_addr,
    input  logic [1:0]  mem_data_width,
    input  logic [31:0] mem_wr_data,
    output logic        mem_rd_ready,
    output logic        mem_wr_ready,
    output logic        mem_rd_valid,
    output logic [31:0] mem_rd_data,
    output logic [24:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int CNT_MAX = (INIT_CYCLES > WAIT_CYCLES + 1) ? INIT_CYCLES : WAIT_CYCLES + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        INIT, IDLE, RD_ACC, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          beat_q, beat_d;
    logic [25:0]   cur_addr_q, cur_addr_d;
    logic [1:0]    cur_width_q, cur_width_d;
    logic [31:0]   cur_data_q, cur_data_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          pend_full_q, pend_full_d;
    logic          pend_rd_q, pend_rd_d;
    logic [25:0]   pend_addr_q, pend_addr_d;
    logic [1:0]    pend_width_q, pend_width_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic          ready_q, ready_d;

    logic          accept, done_now, launch;
    logic          src_rd;
    logic [25:0]   src_addr;
    logic [1:0]    src_width;
    logic [31:0]   src_data;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        cur_addr_d   = cur_addr_q;
        cur_width_d  = cur_width_q;
        cur_data_d   = cur_data_q;
        rd_data_d    = rd_data_q;
        pend_full_d  = pend_full_q;
        pend_rd_d    = pend_rd_q;
        pend_addr_d  = pend_addr_q;
        pend_width_d = pend_width_q;
        pend_data_d  = pend_data_q;
        done_now     = 1'b0;
        accept       = (mem_rd | mem_wr) & ready_q;

        // A held request always takes priority; ready is low while one is held.
        src_rd    = pend_full_q ? pend_rd_q    : mem_rd;
        src_addr  = pend_full_q ? pend_addr_q  : mem_addr;
        src_width = pend_full_q ? pend_width_q : mem_data_width;
        src_data  = pend_full_q ? pend_data_q  : mem_wr_data;

        case (state_q)
            INIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(INIT_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: done_now = 1'b1;
            RD_ACC: begin
                if (cnt_q == CW'(WAIT_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = RD_DONE;
                    if (cur_width_q == 2'b11 && !beat_q) begin
                        rd_data_d[15:0] = sram_dq_in;
                        beat_d          = 1'b1;
                        state_d         = RD_ACC;
                    end else if (cur_width_q == 2'b11) begin
                        rd_data_d[31:16] = sram_dq_in;
                    end else if (cur_width_q == 2'b01) begin
                        rd_data_d = {24'd0, cur_addr_q[0] ? sram_dq_in[15:8] : sram_dq_in[7:0]};
                    end else begin
                        rd_data_d = {16'd0, sram_dq_in};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_DONE: done_now = 1'b1;
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = '0;
            end
            WR_PULSE: begin
                if (cnt_q == CW'(WAIT_CYCLES)) begin
                    state_d = WR_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WR_HOLD: begin
                if (cur_width_q == 2'b11 && !beat_q) begin
                    beat_d  = 1'b1;
                    state_d = WR_SETUP;
                end else begin
                    done_now = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase

        launch = done_now & (pend_full_q | accept);
        if (launch) begin
            beat_d      = 1'b0;
            cnt_d       = '0;
            rd_data_d   = '0;
            pend_full_d = 1'b0;
            cur_width_d = src_width;
            cur_data_d  = src_data;
            case (src_width)
                2'b10:   cur_addr_d = {src_addr[25:1], 1'b0};
                2'b11:   cur_addr_d = {src_addr[25:2], 2'b00};
                default: cur_addr_d = src_addr;
            endcase
            if (src_rd) begin
                state_d = (src_width == 2'b00) ? RD_DONE : RD_ACC;
            end else begin
                state_d = (src_width == 2'b00) ? IDLE : WR_SETUP;
            end
        end else if (done_now) begin
            state_d = IDLE;
        end else if (accept) begin
            pend_full_d  = 1'b1;
            pend_rd_d    = mem_rd;
            pend_addr_d  = mem_addr;
            pend_width_d = mem_data_width;
            pend_data_d  = mem_wr_data;
        end

        ready_d = (state_d != INIT) & ~pend_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            beat_q       <= 1'b0;
            cur_addr_q   <= '0;
            cur_width_q  <= '0;
            cur_data_q   <= '0;
            rd_data_q    <= '0;
            pend_full_q  <= 1'b0;
            pend_rd_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_width_q <= '0;
            pend_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            cur_addr_q   <= cur_addr_d;
            cur_width_q  <= cur_width_d;
            cur_data_q   <= cur_data_d;
            rd_data_q    <= rd_data_d;
            pend_full_q  <= pend_full_d;
            pend_rd_q    <= pend_rd_d;
            pend_addr_q  <= pend_addr_d;
            pend_width_q <= pend_width_d;
            pend_data_q  <= pend_data_d;
            ready_q      <= ready_d;
        end
    end

    logic rd_acc, wr_any, lanes_on, byte_acc;
    assign rd_acc   = (state_q == RD_ACC);
    assign wr_any   = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
    assign lanes_on = rd_acc | wr_any;
    assign byte_acc = (cur_width_q == 2'b01);

    assign mem_rd_ready = ready_q;
    assign mem_wr_ready = ready_q;
    assign mem_rd_valid = (state_q == RD_DONE);
    assign mem_rd_data  = rd_data_q;

    // Aligned 32-bit address has bit 1 clear, so OR-ing the beat selects the upper halfword.
    assign sram_addr   = cur_addr_q[25:1] | {24'd0, beat_q};
    assign sram_dq_oe  = wr_any;
    assign sram_dq_out = !wr_any ? 16'd0 :
                         byte_acc ? {2{cur_data_q[7:0]}} :
                         beat_q   ? cur_data_q[31:16] : cur_data_q[15:0];
    assign sram_ce_n   = ~lanes_on;
    assign sram_oe_n   = ~rd_acc;
    assign sram_we_n   = ~(state_q == WR_PULSE);
    assign sram_ub_n   = ~(lanes_on & (~byte_acc | cur_addr_q[0]));
    assign sram_lb_n   = ~(lanes_on & (~byte_acc | ~cur_addr_q[0]));

endmodule

// File: tb/tb_mem_sram_responder.sv
// tb/tb_mem_sram_responder.sv - directed vector bench for mem_sram_responder with a behavioural SRAM
module tb_mem_sram_responder;

    localparam int WAIT_CYCLES = 2;
    localparam int INIT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [25:0] mem_addr = '0;
    logic [1:0]  mem_data_width = '0;
    logic [31:0] mem_wr_data = '0;
    logic        mem_rd_ready, mem_wr_ready, mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic [24:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    mem_sram_responder #(.WAIT_CYCLES(WAIT_CYCLES), .INIT_CYCLES(INIT_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_width(mem_data_width), .mem_wr_data(mem_wr_data),
        .mem_rd_ready(mem_rd_ready), .mem_wr_ready(mem_wr_ready),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    // Behavioural async SRAM, 1K halfwords, preloaded on the first clock.
    logic [15:0] mem [0:1023];
    logic        mdl_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mdl_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            mem[10'h080] <= 16'h1234;
            mem[10'h081] <= 16'hABCD;
            mem[10'h082] <= 16'hBEEF;
            mdl_loaded   <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq_out[15:8];
        end
    end
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;

    int          beat_idx = 0;
    logic [24:0] beat_addr [0:255];
    logic        prev_oe_n = 1'b1;
    logic [24:0] prev_addr = '0;
    int          we_low = 0;
    logic [24:0] we_addr = '0;
    logic [15:0] we_dq = '0;
    logic        we_ub = 1'b1, we_lb = 1'b1;
    int          valid_cnt = 0;
    int          viol = 0;

    always @(negedge clk) begin
        if (!sram_oe_n && (prev_oe_n || sram_addr != prev_addr)) begin
            beat_addr[beat_idx[7:0]] <= sram_addr;
            beat_idx                 <= beat_idx + 1;
        end
        prev_oe_n <= sram_oe_n;
        prev_addr <= sram_addr;
        if (!sram_we_n) begin
            we_low  <= we_low + 1;
            we_addr <= sram_addr;
            we_dq   <= sram_dq_out;
            we_ub   <= sram_ub_n;
            we_lb   <= sram_lb_n;
        end
        if (mem_rd_valid) valid_cnt <= valid_cnt + 1;
        if (sram_dq_oe && !sram_oe_n) viol <= viol + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller raises rst beforehand; the next posedge is the reset edge.
    task automatic init_check(input string tag);
        int          lows  = 0;
        int          noisy = 0;
        int          vc0;
        logic [31:0] rdd = '0;
        logic [24:0] sa  = '0;
        logic [15:0] dqo = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        vc0 = valid_cnt;
        for (int i = 0; i < INIT_CYCLES; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rdd = mem_rd_data;
                sa  = sram_addr;
                dqo = sram_dq_out;
            end
            if (!mem_rd_ready && !mem_wr_ready) lows++;
            if (!sram_ce_n || !sram_oe_n || !sram_we_n || !sram_ub_n || !sram_lb_n ||
                sram_dq_oe || mem_rd_valid) noisy++;
        end
        check({tag, "_ready_low_cycles"}, 32'(lows), 32'(INIT_CYCLES));
        check({tag, "_strobes_quiet"}, 32'(noisy), 32'd0);
        check({tag, "_reset_rd_data"}, rdd, 32'd0);
        check({tag, "_reset_sram_addr"}, 32'(sa), 32'd0);
        check({tag, "_reset_dq_out"}, 32'(dqo), 32'd0);
        @(negedge clk);
        check({tag, "_ready_after_init"}, 32'({mem_rd_ready, mem_wr_ready}), 32'd3);
        #1;
        check({tag, "_no_rd_valid"}, 32'(valid_cnt - vc0), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(mem_rd_ready && mem_wr_ready) && t < 60);
        #1;
        if (t >= 60) check({tag, "_ready_timeout"}, 32'(mem_rd_ready), 32'd1);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  width;
        logic [25:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_beats;
        logic [24:0] exp_sa;
        int          exp_we;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int b0, w0, v0, lat;

        vecs[0]  = '{1'b1, 1'b0, 2'b10, 26'h104, 32'h0,        32'h0000BEEF, 4, 1, 25'h82, 0};
        vecs[1]  = '{1'b1, 1'b0, 2'b11, 26'h103, 32'h0,        32'hABCD1234, 7, 2, 25'h80, 0};
        vecs[2]  = '{1'b1, 1'b0, 2'b01, 26'h105, 32'h0,        32'h000000BE, 4, 1, 25'h82, 0};
        vecs[3]  = '{1'b1, 1'b0, 2'b01, 26'h104, 32'h0,        32'h000000EF, 4, 1, 25'h82, 0};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 26'h104, 32'h0,        32'h00000000, 1, 0, 25'h0,  0};
        vecs[5]  = '{1'b0, 1'b1, 2'b10, 26'h021, 32'h1234CAFE, 32'h0,        0, 0, 25'h0,  3};
        vecs[6]  = '{1'b0, 1'b1, 2'b11, 26'h042, 32'hDEADBEEF, 32'h0,        0, 0, 25'h0,  6};
        vecs[7]  = '{1'b1, 1'b0, 2'b11, 26'h040, 32'h0,        32'hDEADBEEF, 7, 2, 25'h20, 0};
        vecs[8]  = '{1'b1, 1'b0, 2'b10, 26'h020, 32'h0,        32'h0000CAFE, 4, 1, 25'h10, 0};
        vecs[9]  = '{1'b1, 1'b1, 2'b10, 26'h020, 32'h00001111, 32'h0000CAFE, 4, 1, 25'h10, 0};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 26'h020, 32'h00009999, 32'h0,        0, 0, 25'h0,  0};
        vecs[11] = '{1'b1, 1'b0, 2'b10, 26'h021, 32'h0,        32'h0000CAFE, 4, 1, 25'h10, 0};
        vecs[12] = '{1'b1, 1'b0, 2'b01, 26'h010, 32'h0,        32'h00000000, 4, 1, 25'h08, 0};
        vecs[13] = '{1'b1, 1'b0, 2'b01, 26'h011, 32'h0,        32'h0000005A, 4, 1, 25'h08, 0};

        repeat (3) @(posedge clk);
        init_check("por");

        // Single-byte write to the odd byte: upper lane only, byte replicated on DQ.
        wait_ready("b8");
        w0 = we_low;
        mem_wr = 1'b1; mem_data_width = 2'b01; mem_addr = 26'h011; mem_wr_data = 32'hFFFFFF5A;
        @(posedge clk);
        #1 mem_wr = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("b8_we_low_cycles", 32'(we_low - w0), 32'd3);
        check("b8_sram_addr", 32'(we_addr), 32'h8);
        check("b8_dq_out", 32'(we_dq), 32'h5A5A);
        check("b8_ub_lb", 32'({we_ub, we_lb}), 32'b01);
        check("b8_mem", 32'(mem[8]), 32'h5A00);

        for (int i = 0; i < 14; i++) begin
            wait_ready($sformatf("v%0d", i));
            b0 = beat_idx; w0 = we_low; v0 = valid_cnt;
            mem_rd = vecs[i].rd; mem_wr = vecs[i].wr; mem_data_width = vecs[i].width;
            mem_addr = vecs[i].addr; mem_wr_data = vecs[i].wdata;
            @(posedge clk);
            #1 mem_rd = 1'b0; mem_wr = 1'b0;
            if (vecs[i].rd) begin
                lat = 1;
                @(negedge clk);
                while (!mem_rd_valid && lat < 40) begin
                    lat++;
                    @(negedge clk);
                end
                check($sformatf("v%0d_rd_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
                check($sformatf("v%0d_rd_data", i), mem_rd_data, vecs[i].exp_data);
                @(posedge clk);
                #1;
                check($sformatf("v%0d_beats", i), 32'(beat_idx - b0), 32'(vecs[i].exp_beats));
                if (vecs[i].exp_beats > 0)
                    check($sformatf("v%0d_sram_addr0", i), 32'(beat_addr[b0[7:0]]), 32'(vecs[i].exp_sa));
                if (vecs[i].exp_beats > 1)
                    check($sformatf("v%0d_sram_addr1", i), 32'(beat_addr[8'(b0 + 1)]),
                          32'(vecs[i].exp_sa + 25'd1));
            end else begin
                repeat (12) @(posedge clk);
                #1;
                check($sformatf("v%0d_wr_no_valid", i), 32'(valid_cnt - v0), 32'd0);
            end
            check($sformatf("v%0d_we_cycles", i), 32'(we_low - w0), 32'(vecs[i].exp_we));
        end

        // Three 32-bit writes two cycles apart: second is held, third is refused.
        wait_ready("b2b");
        mem_wr = 1'b1; mem_data_width = 2'b11; mem_addr = 26'h080; mem_wr_data = 32'h11112222;
        @(posedge clk); #1 mem_wr = 1'b0;
        @(posedge clk); #1 mem_wr = 1'b1; mem_addr = 26'h084; mem_wr_data = 32'h33334444;
        @(posedge clk); #1 mem_wr = 1'b0;
        @(posedge clk); #1;
        check("b2b_ready_low_when_pending", 32'({mem_rd_ready, mem_wr_ready}), 32'd0);
        mem_wr = 1'b1; mem_addr = 26'h088; mem_wr_data = 32'h55556666;
        @(posedge clk); #1 mem_wr = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("b2b_first", {mem[10'h041], mem[10'h040]}, 32'h11112222);
        check("b2b_second", {mem[10'h043], mem[10'h042]}, 32'h33334444);
        check("b2b_third_dropped", {mem[10'h045], mem[10'h044]}, 32'h0);
        check("b2b_ready_back", 32'(mem_wr_ready), 32'd1);

        // Reset in the middle of the write pulse.
        wait_ready("rstw");
        v0 = valid_cnt;
        mem_wr = 1'b1; mem_data_width = 2'b10; mem_addr = 26'h300; mem_wr_data = 32'h7777;
        @(posedge clk); #1 mem_wr = 1'b0;
        lat = 0;
        @(negedge clk);
        while (sram_we_n && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        check("rstw_we_pulse_seen", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        init_check("rstw");
        check("rstw_no_valid_total", 32'(valid_cnt - v0), 32'd0);

        check("dq_oe_with_oe_n_low", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
